// File: rtl/fp_pkg.sv
// Shared constants for the streaming FP classifier: one-hot class bit positions
// (FCLASS order), sticky flag positions and common format presets.
package fp_pkg;

   localparam int CLS_W     = 10;
   localparam int CLS_NINF  = 0;
   localparam int CLS_NNORM = 1;
   localparam int CLS_NSUB  = 2;
   localparam int CLS_NZERO = 3;
   localparam int CLS_PZERO = 4;
   localparam int CLS_PSUB  = 5;
   localparam int CLS_PNORM = 6;
   localparam int CLS_PINF  = 7;
   localparam int CLS_SNAN  = 8;
   localparam int CLS_QNAN  = 9;

   localparam int STK_W    = 5;
   localparam int STK_ZERO = 0;
   localparam int STK_SUB  = 1;
   localparam int STK_INF  = 2;
   localparam int STK_QNAN = 3;
   localparam int STK_SNAN = 4;

   localparam int FP16_EXP_W = 5;
   localparam int FP16_MAN_W = 10;
   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;

   typedef struct packed {
      logic [CLS_W-1:0] cls;
      logic             sign;
   } fpResult_t;

endpackage

// File: rtl/fp_class_decode.sv
// Purely combinational decode of one IEEE-754 operand into its one-hot class
// code and sign bit; format is set by EXP_W/MAN_W.
module fp_class_decode
   import fp_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic [W-1:0]     i_data,
   output logic [CLS_W-1:0] o_class,
   output logic             o_sign
);

   logic             w_sign;
   logic [EXP_W-1:0] w_exp;
   logic [MAN_W-1:0] w_man;
   logic             w_expOnes;
   logic             w_expZeroes;
   logic             w_manZero;
   logic             w_quiet;

   assign w_sign      = i_data[W-1];
   assign w_exp       = i_data[W-2:MAN_W];
   assign w_man       = i_data[MAN_W-1:0];
   assign w_expOnes   = &w_exp;
   assign w_expZeroes = ~|w_exp;
   assign w_manZero   = ~|w_man;
   assign w_quiet     = w_man[MAN_W-1];
   assign o_sign      = w_sign;

   // NaN classes ignore the sign; every other class is split by sign
   always_comb begin
      o_class = '0;
      if (w_expOnes) begin
         if (w_manZero)
            o_class[w_sign ? CLS_NINF : CLS_PINF] = 1'b1;
         else if (w_quiet)
            o_class[CLS_QNAN] = 1'b1;
         else
            o_class[CLS_SNAN] = 1'b1;
      end else if (w_expZeroes) begin
         if (w_manZero)
            o_class[w_sign ? CLS_NZERO : CLS_PZERO] = 1'b1;
         else
            o_class[w_sign ? CLS_NSUB : CLS_PSUB] = 1'b1;
      end else begin
         o_class[w_sign ? CLS_NNORM : CLS_PNORM] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_classifier_stream.sv
// Streaming FP classifier: valid/ready input, 2-entry result FIFO, sticky
// exception flags and a saturating NaN counter updated on every accepted operand.
module fp_classifier_stream
   import fp_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int CNT_W = 8,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CLS_W-1:0] out_class,
   output logic             out_sign,
   output logic [STK_W-1:0] sticky,
   input  logic             clr_sticky,
   output logic [CNT_W-1:0] nan_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CLS_W-1:0] w_class;
   logic             w_sign;
   logic             w_accept;
   logic             w_pop;
   logic             w_isNan;
   logic [STK_W-1:0] w_newFlags;
   logic [STK_W-1:0] w_stickyNext;
   logic [CNT_W-1:0] w_cntBase;
   logic [CNT_W-1:0] w_cntNext;

   fpResult_t        r_mem [2];
   logic [1:0]       r_count;
   logic             r_rdPtr;
   logic             r_wrPtr;
   logic [STK_W-1:0] r_sticky;
   logic [CNT_W-1:0] r_nanCnt;

   fp_class_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_decode (
      .i_data  (in_data),
      .o_class (w_class),
      .o_sign  (w_sign)
   );

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_accept  = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign out_class = out_valid ? r_mem[r_rdPtr].cls  : '0;
   assign out_sign  = out_valid ? r_mem[r_rdPtr].sign : 1'b0;
   assign sticky    = r_sticky;
   assign nan_cnt   = r_nanCnt;

   // An accept in the same cycle as a clear lands on top of the cleared value
   always_comb begin
      w_newFlags           = '0;
      w_newFlags[STK_SNAN] = w_class[CLS_SNAN];
      w_newFlags[STK_QNAN] = w_class[CLS_QNAN];
      w_newFlags[STK_INF]  = w_class[CLS_NINF]  | w_class[CLS_PINF];
      w_newFlags[STK_SUB]  = w_class[CLS_NSUB]  | w_class[CLS_PSUB];
      w_newFlags[STK_ZERO] = w_class[CLS_NZERO] | w_class[CLS_PZERO];
      w_isNan              = w_class[CLS_SNAN] | w_class[CLS_QNAN];
      w_stickyNext         = (clr_sticky ? '0 : r_sticky) | (w_accept ? w_newFlags : '0);
      w_cntBase            = clr_sticky ? '0 : r_nanCnt;
      w_cntNext            = w_cntBase;
      if (w_accept && w_isNan && (w_cntBase != CNT_MAX))
         w_cntNext = w_cntBase + 1'b1;
   end

   // Storage needs no reset: the head is masked to zero while the FIFO is empty
   always_ff @(posedge clk) begin
      if (w_accept)
         r_mem[r_wrPtr] <= '{cls: w_class, sign: w_sign};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count  <= 2'd0;
         r_rdPtr  <= 1'b0;
         r_wrPtr  <= 1'b0;
         r_sticky <= '0;
         r_nanCnt <= '0;
      end else begin
         if (w_accept)
            r_wrPtr <= ~r_wrPtr;
         if (w_pop)
            r_rdPtr <= ~r_rdPtr;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         r_sticky <= w_stickyNext;
         r_nanCnt <= w_cntNext;
      end
   end

endmodule

// File: tb/tb_fp_classifier_stream.sv
// Directed bench for fp_classifier_stream: FP16 classes, FP32 instance,
// backpressure, sticky/clear, counter saturation and mid-stream reset.
module tb_fp_classifier_stream;

   logic        clk;
   logic        reset;

   logic        inValid, inReady, outValid, outReady, outSign, clrSticky;
   logic [15:0] inData;
   logic [9:0]  outClass;
   logic [4:0]  sticky;
   logic [7:0]  nanCnt;

   logic        f32InValid, f32InReady, f32OutValid, f32OutSign;
   logic [31:0] f32InData;
   logic [9:0]  f32OutClass;
   logic [4:0]  f32Sticky;
   logic [7:0]  f32NanCnt;

   logic        satInValid, satInReady, satOutValid, satOutSign;
   logic [15:0] satInData;
   logic [9:0]  satOutClass;
   logic [4:0]  satSticky;
   logic [1:0]  satNanCnt;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] f32Vec [3] = '{32'hFF800000, 32'h7FC00000, 32'h00000001};
   logic [9:0]  f32Exp [3] = '{10'h001, 10'h200, 10'h020};

   fp_classifier_stream #(.EXP_W(5), .MAN_W(10), .CNT_W(8)) dut16 (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
      .out_valid(outValid), .out_ready(outReady), .out_class(outClass), .out_sign(outSign),
      .sticky(sticky), .clr_sticky(clrSticky), .nan_cnt(nanCnt)
   );

   fp_classifier_stream #(.EXP_W(8), .MAN_W(23), .CNT_W(8)) dut32 (
      .clk(clk), .reset(reset), .in_valid(f32InValid), .in_ready(f32InReady), .in_data(f32InData),
      .out_valid(f32OutValid), .out_ready(1'b1), .out_class(f32OutClass), .out_sign(f32OutSign),
      .sticky(f32Sticky), .clr_sticky(1'b0), .nan_cnt(f32NanCnt)
   );

   fp_classifier_stream #(.EXP_W(5), .MAN_W(10), .CNT_W(2)) dutSat (
      .clk(clk), .reset(reset), .in_valid(satInValid), .in_ready(satInReady), .in_data(satInData),
      .out_valid(satOutValid), .out_ready(1'b1), .out_class(satOutClass), .out_sign(satOutSign),
      .sticky(satSticky), .clr_sticky(1'b0), .nan_cnt(satNanCnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Present one operand for one edge, then check the FIFO head just after it
   task automatic applyStimulus(input string tag, input logic [15:0] data, input logic clr,
                                input logic [9:0] expClass, input logic expSign);
      @(negedge clk);
      inValid   = 1'b1;
      inData    = data;
      clrSticky = clr;
      @(posedge clk);
      #1;
      inValid   = 1'b0;
      clrSticky = 1'b0;
      checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, "_class"}, 32'(outClass), 32'(expClass));
      checkOutput({tag, "_sign"},  32'(outSign),  32'(expSign));
   endtask

   initial begin
      reset      = 1'b1;
      inValid    = 1'b0;
      inData     = '0;
      outReady   = 1'b1;
      clrSticky  = 1'b0;
      f32InValid = 1'b0;
      f32InData  = '0;
      satInValid = 1'b0;
      satInData  = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_outValid", 32'(outValid), 32'd0);
      checkOutput("rst_inReady",  32'(inReady),  32'd1);
      checkOutput("rst_outClass", 32'(outClass), 32'd0);
      checkOutput("rst_sticky",   32'(sticky),   32'd0);
      checkOutput("rst_nanCnt",   32'(nanCnt),   32'd0);
      reset = 1'b0;

      // Nothing may appear at the head in the same cycle the operand is offered
      @(negedge clk);
      checkOutput("lat_empty", 32'(outValid), 32'd0);

      applyStimulus("pinf",  16'h7C00, 1'b0, 10'h080, 1'b0);
      applyStimulus("ninf",  16'hFC00, 1'b0, 10'h001, 1'b1);
      applyStimulus("qnan",  16'h7E00, 1'b0, 10'h200, 1'b0);
      applyStimulus("snan",  16'h7D00, 1'b0, 10'h100, 1'b0);
      applyStimulus("pzero", 16'h0000, 1'b0, 10'h010, 1'b0);
      applyStimulus("nsub",  16'h8001, 1'b0, 10'h004, 1'b1);
      applyStimulus("pnorm", 16'h3C00, 1'b0, 10'h040, 1'b0);
      checkOutput("stk_all", 32'(sticky), 32'h1F);
      checkOutput("cnt_two", 32'(nanCnt), 32'd2);

      @(negedge clk);
      clrSticky = 1'b1;
      @(posedge clk);
      #1;
      clrSticky = 1'b0;
      checkOutput("clr_sticky", 32'(sticky), 32'd0);
      checkOutput("clr_nanCnt", 32'(nanCnt), 32'd0);

      applyStimulus("stk_snan", 16'h7D00, 1'b0, 10'h100, 1'b0);
      applyStimulus("stk_sub",  16'h0001, 1'b0, 10'h020, 1'b0);
      checkOutput("stk_10010", 32'(sticky), 32'b10010);
      checkOutput("stk_cnt1",  32'(nanCnt), 32'd1);
      applyStimulus("clr_acc", 16'h7E00, 1'b1, 10'h200, 1'b0);
      checkOutput("clr_acc_sticky", 32'(sticky), 32'b01000);
      checkOutput("clr_acc_cnt",    32'(nanCnt), 32'd1);

      @(posedge clk);
      #1;
      checkOutput("drain", 32'(outValid), 32'd0);

      // Backpressure: two entries fill the buffer, the third operand waits
      @(negedge clk);
      outReady = 1'b0;
      inValid  = 1'b1;
      inData   = 16'h3C00;
      @(posedge clk);
      #1;
      inData = 16'h7C00;
      checkOutput("bp_head",   32'(outClass), 32'h040);
      checkOutput("bp_ready1", 32'(inReady),  32'd1);
      @(posedge clk);
      #1;
      inData = 16'h0000;
      checkOutput("bp_full", 32'(inReady), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("bp_held",  32'(inReady),  32'd0);
      checkOutput("bp_stable", 32'(outClass), 32'h040);
      @(negedge clk);
      outReady = 1'b1;
      checkOutput("bp_out0", 32'(outClass), 32'h040);
      @(posedge clk);
      #1;
      checkOutput("bp_out1",   32'(outClass), 32'h080);
      checkOutput("bp_ready2", 32'(inReady),  32'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("bp_out2", 32'(outClass), 32'h010);
      @(posedge clk);
      #1;
      checkOutput("bp_empty", 32'(outValid), 32'd0);

      // Fill the buffer with two NaNs after a clear, then reset mid-stream
      @(negedge clk);
      outReady  = 1'b0;
      clrSticky = 1'b1;
      @(posedge clk);
      #1;
      clrSticky = 1'b0;
      applyStimulus("mr_fill0", 16'h7E00, 1'b0, 10'h200, 1'b0);
      applyStimulus("mr_fill1", 16'h7D00, 1'b0, 10'h200, 1'b0);
      checkOutput("mr_full", 32'(inReady), 32'd0);
      checkOutput("mr_cnt2", 32'(nanCnt),  32'd2);
      @(negedge clk);
      reset   = 1'b1;
      inValid = 1'b1;
      inData  = 16'h7C00;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      inValid = 1'b0;
      checkOutput("mr_outValid", 32'(outValid), 32'd0);
      checkOutput("mr_inReady",  32'(inReady),  32'd1);
      checkOutput("mr_sticky",   32'(sticky),   32'd0);
      checkOutput("mr_nanCnt",   32'(nanCnt),   32'd0);
      checkOutput("mr_outClass", 32'(outClass), 32'd0);
      outReady = 1'b1;
      applyStimulus("mr_after", 16'h7C00, 1'b0, 10'h080, 1'b0);

      // FP32 instance
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         f32InValid = 1'b1;
         f32InData  = f32Vec[i];
         @(posedge clk);
         #1;
         f32InValid = 1'b0;
         checkOutput($sformatf("fp32_%0d_valid", i), 32'(f32OutValid), 32'd1);
         checkOutput($sformatf("fp32_%0d_class", i), 32'(f32OutClass), 32'(f32Exp[i]));
      end

      // Two-bit NaN counter must stop at 3
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         satInValid = 1'b1;
         satInData  = (i % 2 == 0) ? 16'h7E00 : 16'hFD00;
         @(posedge clk);
         #1;
         satInValid = 1'b0;
         checkOutput($sformatf("sat_%0d", i), 32'(satNanCnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fp_classifier_stream.md
Name: fp_classifier_stream

Overview:
- Parametrised, streaming IEEE-754 classifier for any EXP_W/MAN_W format (half, single, ...).
- Accepts one operand per cycle over a valid/ready handshake and emits a registered 10-bit one-hot class code (FCLASS bit order) plus sign.
- Holds results in a 2-entry output buffer and keeps sticky exception flags and a saturating NaN counter.
- Sits between the operand-fetch path and the FP unit / CSR flag logic of the multi-cycle datapath.

Parameters:
- EXP_W, 5, exponent field width (>=2).
- MAN_W, 10, mantissa field width (>=2).
- CNT_W, 8, width of the saturating NaN counter.
- (local) W = 1+EXP_W+MAN_W, operand width.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  W  operand {sign, exp, man}.
- out_valid  output  1  class result valid.
- out_ready  input  1  consumer accepts the result.
- out_class  output  10  one-hot class of the head result.
- out_sign  output  1  sign bit of the head operand.
- sticky  output  5  {snan, qnan, inf, subnormal, zero} seen since last clear.
- clr_sticky  input  1  clears sticky and nan_cnt.
- nan_cnt  output  CNT_W  count of accepted NaNs (qNaN+sNaN), saturating.

Behaviour:
- Field decode: expOnes = &exp; expZeroes = ~|exp; manZero = ~|man; quiet = man[MAN_W-1].
- Classes (mutually exclusive, exactly one out_class bit set):
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -zero, bit4 +zero, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN.
  - NaN bits ignore sign.
  - sNaN = expOnes & ~manZero & ~quiet. qNaN = expOnes & quiet.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Buffer: 2-entry FIFO of {class, sign}, occupancy count 0..2.
  - in_ready = (count != 2). This is a combinational decode of registered state only, with no path from out_ready.
  - out_valid = (count != 0). out_class/out_sign show the head entry; they hold stable while out_valid & ~out_ready.
- Latency: an operand accepted in cycle N is visible at the head no earlier than cycle N+1. With count 0 and out_ready high, throughput is one operand per cycle.
- Count updates:
  - count 1 with push+pop: count stays 1 and the new entry becomes the head next cycle.
  - count 0 with pop: impossible.
  - count 2 with push: impossible, because in_ready is low.
- Order preserved strictly FIFO.
- Sticky/counter:
  - Updated on Accept, not on Pop.
  - Each sticky bit is set when its class is accepted: inf = either sign, subnormal = either sign, zero = either sign.
  - nan_cnt increments on each accepted sNaN or qNaN and saturates at 2^CNT_W-1.
  - clr_sticky zeroes both registers next cycle. An Accept in the same cycle wins: the flag ends set and nan_cnt ends at 1 if that operand is a NaN.
- Reset: count=0, out_valid=0, in_ready=1 (combinational from count after reset), out_class=0, out_sign=0, sticky=0, nan_cnt=0.
  - Reset asserted mid-stream discards buffered entries. Inputs presented during reset are not accepted.
  - FIFO storage contents are don't-care, but out_class must read 0 while out_valid=0.

Decomposition:
- Shared package fp_pkg:
  - class bit index constants (CLS_NINF..CLS_QNAN).
  - sticky bit indices.
  - format presets: FP16 (5,10), FP32 (8,23).
- Sub-module fp_class_decode: purely combinational W-bit to {class[9:0], sign}, parametrised by EXP_W/MAN_W.
- Top level holds the FIFO, sticky flags and counter.

Test Plan:
- FP16 single operands with out_ready=1:
  - 16'h7C00 -> out_class 10'h080; 16'hFC00 -> 10'h001.
  - 16'h7E00 -> 10'h200; 16'h7D00 -> 10'h100.
  - 16'h0000 -> 10'h010; 16'h8001 -> 10'h004.
  - 16'h3C00 -> 10'h040; each result appears 1 cycle after Accept.
- FP32 instance (EXP_W=8, MAN_W=23): 32'hFF800000 -> 10'h001; 32'h7FC00000 -> 10'h200; 32'h00000001 -> 10'h020.
- Backpressure, out_ready=0:
  - Push 16'h3C00, 16'h7C00, 16'h0000 back-to-back -> in_ready=0 after the second Accept and the third is held.
  - Raise out_ready -> outputs 10'h040, 10'h080, 10'h010 in order with no loss.
- Sticky, clear and saturation:
  - Push 16'h7D00 then 16'h0001 -> sticky=5'b10010, nan_cnt=1.
  - clr_sticky together with an Accept of 16'h7E00 -> next cycle sticky=5'b01000, nan_cnt=1.
  - CNT_W=2 with 5 NaNs -> nan_cnt=3.
- Reset mid-operation: with 2 entries buffered and nan_cnt=2, assert reset for 1 cycle -> out_valid=0, in_ready=1, sticky=0, nan_cnt=0, out_class=0; the next push of 16'h7C00 -> 10'h080.
